// File: rtl/fft2d_tile_feeder.sv
// Tile sequencer in front of the 4x4 2-D FFT: one read per tile, one fft_next per returned tile.
// Define FEEDER_REAL_INPUT_EN to zero the imaginary half of every element sent to the FFT.
module fft2d_tile_feeder #(
    parameter int unsigned ADDR_WIDTH = 13,
    parameter int unsigned TILE_GAP   = 0,
    parameter int unsigned CNT_WIDTH  = 14
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [CNT_WIDTH-1:0]  num_tiles,
    input  logic                  pause,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] mem_read_address,
    input  logic [1023:0]         mem_out,
    output logic [1023:0]         fft_in,
    output logic                  fft_next
);

    localparam int unsigned GapWidth = (TILE_GAP > 0) ? $clog2(TILE_GAP + 1) : 1;

    typedef enum logic [1:0] {StIdle, StIssue, StDrain, StFinish} state_e;

    state_e                state_q, state_d;
    logic [CNT_WIDTH-1:0]  remaining_q, remaining_d;
    logic [ADDR_WIDTH-1:0] next_addr_q, next_addr_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic [GapWidth-1:0]   gap_q, gap_d;
    logic                  fire;
    logic                  rd_valid_q;   // address on the memory port this cycle
    logic                  mem_valid_q;  // mem_out holds a requested tile this cycle
    logic                  fft_next_q;
    logic [1023:0]         fft_in_q;
    logic [1023:0]         tile_in;

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        next_addr_d = next_addr_q;
        rd_addr_d   = rd_addr_q;
        fire        = 1'b0;
        gap_d       = (gap_q != '0) ? gap_q - GapWidth'(1) : gap_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (num_tiles == '0) begin
                        state_d = StFinish;
                    end else if (!pause) begin
                        // First read goes out on the edge that accepts start.
                        fire        = 1'b1;
                        rd_addr_d   = base_addr;
                        next_addr_d = base_addr + ADDR_WIDTH'(1);
                        remaining_d = num_tiles - CNT_WIDTH'(1);
                        state_d     = (num_tiles == CNT_WIDTH'(1)) ? StDrain : StIssue;
                    end else begin
                        next_addr_d = base_addr;
                        remaining_d = num_tiles;
                        state_d     = StIssue;
                    end
                end
            end
            StIssue: begin
                if (!pause && gap_q == '0) begin
                    fire        = 1'b1;
                    rd_addr_d   = next_addr_q;
                    next_addr_d = next_addr_q + ADDR_WIDTH'(1);
                    remaining_d = remaining_q - CNT_WIDTH'(1);
                    if (remaining_q == CNT_WIDTH'(1)) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                if (!rd_valid_q && !mem_valid_q) begin
                    state_d = StFinish;
                end
            end
            StFinish: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (fire) begin
            gap_d = GapWidth'(TILE_GAP);
        end
    end

`ifdef FEEDER_REAL_INPUT_EN
    always_comb begin
        tile_in = mem_out;
        for (int e = 0; e < 16; e++) begin
            tile_in[e*64 +: 32] = '0;
        end
    end
`else
    assign tile_in = mem_out;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            remaining_q <= '0;
            next_addr_q <= '0;
            rd_addr_q   <= '0;
            gap_q       <= '0;
            rd_valid_q  <= 1'b0;
            mem_valid_q <= 1'b0;
            fft_next_q  <= 1'b0;
            fft_in_q    <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            next_addr_q <= next_addr_d;
            rd_addr_q   <= rd_addr_d;
            gap_q       <= gap_d;
            rd_valid_q  <= fire;
            mem_valid_q <= rd_valid_q;
            fft_next_q  <= mem_valid_q;
            if (mem_valid_q) begin
                fft_in_q <= tile_in;
            end
        end
    end

    assign busy             = (state_q != StIdle);
    assign done             = (state_q == StFinish);
    assign mem_read_address = rd_addr_q;
    assign fft_in           = fft_in_q;
    assign fft_next         = fft_next_q;

endmodule

// File: tb/tb_fft2d_tile_feeder.sv
// Scoreboard bench for fft2d_tile_feeder: instance 0 with TILE_GAP=0, instance 1 with TILE_GAP=2.
// Expectations are queued with their due cycle; the negedge monitor compares and retires them.
module tb_fft2d_tile_feeder;

    typedef enum logic [1:0] {KNext, KAddr, KDone, KBusy} kind_e;
    typedef struct {
        int            dut;
        kind_e         kind;
        int            cyc;
        logic [1023:0] val;
    } exp_t;

    logic          clk;
    logic          reset;
    logic          start            [2];
    logic [12:0]   base_addr        [2];
    logic [13:0]   num_tiles        [2];
    logic          pause            [2];
    logic          busy             [2];
    logic          done             [2];
    logic [12:0]   mem_read_address [2];
    logic [1023:0] mem_out          [2];
    logic [1023:0] fft_in           [2];
    logic          fft_next         [2];

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    for (genvar d = 0; d < 2; d++) begin : g_dut
        fft2d_tile_feeder #(
            .ADDR_WIDTH(13),
            .TILE_GAP  (2 * d),
            .CNT_WIDTH (14)
        ) u_dut (
            .clk             (clk),
            .reset           (reset),
            .start           (start[d]),
            .base_addr       (base_addr[d]),
            .num_tiles       (num_tiles[d]),
            .pause           (pause[d]),
            .busy            (busy[d]),
            .done            (done[d]),
            .mem_read_address(mem_read_address[d]),
            .mem_out         (mem_out[d]),
            .fft_in          (fft_in[d]),
            .fft_next        (fft_next[d])
        );
    end

    // Each element: real = {000, addr, 000, e}, imag = {3F80, 000, addr}.
    function automatic logic [1023:0] tile_of(input logic [12:0] a);
        logic [1023:0] t;
        for (int e = 0; e < 16; e++) begin
            t[e*64+32 +: 32] = {3'b000, a, 12'h000, 4'(e)};
            t[e*64 +: 32]    = {16'h3F80, 3'b000, a};
        end
        return t;
    endfunction

    function automatic logic [1023:0] exp_tile(input logic [12:0] a);
        logic [1023:0] t;
        t = tile_of(a);
`ifdef FEEDER_REAL_INPUT_EN
        for (int e = 0; e < 16; e++) begin
            t[e*64 +: 32] = 32'h0;
        end
`endif
        return t;
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int d = 0; d < 2; d++) begin
            mem_out[d] <= tile_of(mem_read_address[d]);
        end
    end

    // Monitor: retire every expectation due this cycle, flag unexpected strobes.
    always @(negedge clk) begin
        logic [1:0] hit_next;
        logic [1:0] hit_done;
        exp_t       e;
        hit_next = '0;
        hit_done = '0;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc) begin
                e = sb[i];
                checks++;
                case (e.kind)
                    KNext: begin
                        hit_next[e.dut] = 1'b1;
                        if (fft_next[e.dut] !== 1'b1 || fft_in[e.dut] !== e.val) begin
                            errors++;
                            $display("FAIL fft_next dut%0d cyc %0d: next=%b fft_in[63:0]=%h, need next=1 fft_in[63:0]=%h",
                                     e.dut, cyc, fft_next[e.dut], fft_in[e.dut][63:0], e.val[63:0]);
                        end
                    end
                    KAddr: begin
                        if (mem_read_address[e.dut] !== e.val[12:0]) begin
                            errors++;
                            $display("FAIL address dut%0d cyc %0d: got %h need %h",
                                     e.dut, cyc, mem_read_address[e.dut], e.val[12:0]);
                        end
                    end
                    KDone: begin
                        hit_done[e.dut] = 1'b1;
                        if (done[e.dut] !== 1'b1) begin
                            errors++;
                            $display("FAIL done dut%0d cyc %0d: got %b need 1", e.dut, cyc, done[e.dut]);
                        end
                    end
                    default: begin
                        if (busy[e.dut] !== e.val[0]) begin
                            errors++;
                            $display("FAIL busy dut%0d cyc %0d: got %b need %b",
                                     e.dut, cyc, busy[e.dut], e.val[0]);
                        end
                    end
                endcase
                sb.delete(i);
            end
        end
        for (int d = 0; d < 2; d++) begin
            if (fft_next[d] === 1'b1 && !hit_next[d]) begin
                checks++;
                errors++;
                $display("FAIL stray fft_next dut%0d cyc %0d: got 1 need 0", d, cyc);
            end
            if (done[d] === 1'b1 && !hit_done[d]) begin
                checks++;
                errors++;
                $display("FAIL stray done dut%0d cyc %0d: got 1 need 0", d, cyc);
            end
        end
    end

    task automatic push(input int d, input kind_e k, input int c, input logic [1023:0] v);
        exp_t e;
        e.dut  = d;
        e.kind = k;
        e.cyc  = c;
        e.val  = v;
        sb.push_back(e);
    endtask

    task automatic chk(input string name, input logic [1023:0] got, input logic [1023:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h need %h", name, got[63:0], want[63:0]);
        end
    endtask

    // Drives start during cycle t; returns one cycle later with start cleared.
    task automatic do_start(input int d, input logic [12:0] b, input logic [13:0] n,
                            output int t);
        @(posedge clk);
        #1;
        start[d]     = 1'b1;
        base_addr[d] = b;
        num_tiles[d] = n;
        t            = cyc;
        @(posedge clk);
        #1;
        start[d] = 1'b0;
    endtask

    // Expected schedule of an unpaused run on an instance with gap g.
    task automatic expect_run(input int d, input int t, input logic [12:0] b, input int n,
                              input int g);
        logic [12:0] a;
        for (int j = 0; j < n; j++) begin
            a = b + 13'(j);
            push(d, KAddr, t + 1 + j * (g + 1), 1024'(a));
            push(d, KNext, t + 3 + j * (g + 1), exp_tile(a));
        end
        push(d, KDone, t + 4 + (n - 1) * (g + 1), '0);
    endtask

    task automatic drain(input int limit);
        int n;
        n = 0;
        while (sb.size() != 0 && n < limit) begin
            @(posedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations pending, need 0", sb.size());
            sb.delete();
        end
        repeat (3) @(posedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int addr_off [6];
        int next_off [6];
        addr_off = '{1, 2, 7, 8, 9, 10};
        next_off = '{3, 4, 9, 10, 11, 12};
        reset = 1'b1;
        for (int d = 0; d < 2; d++) begin
            start[d]     = 1'b0;
            base_addr[d] = '0;
            num_tiles[d] = '0;
            pause[d]     = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("reset busy", 1024'(busy[0]), '0);
        chk("reset done", 1024'(done[0]), '0);
        chk("reset fft_next", 1024'(fft_next[0]), '0);
        chk("reset address", 1024'(mem_read_address[0]), '0);
        chk("reset fft_in", fft_in[0], '0);
        reset = 1'b0;

        // Basic run, with a start pulse while busy that must be ignored.
        do_start(0, 13'h010, 14'd4, t);
        expect_run(0, t, 13'h010, 4, 0);
        push(0, KBusy, t + 1, 1024'(1));
        push(0, KBusy, t + 7, 1024'(1));
        push(0, KBusy, t + 8, 1024'(0));
        @(posedge clk);
        #1;
        start[0]     = 1'b1;
        base_addr[0] = 13'h100;
        num_tiles[0] = 14'd2;
        @(posedge clk);
        #1;
        start[0] = 1'b0;
        drain(40);

        // Address wrap with a two-cycle gap.
        do_start(1, 13'h1FFE, 14'd3, t);
        expect_run(1, t, 13'h1FFE, 3, 2);
        drain(40);

        // Pause for four cycles after the second address.
        do_start(0, 13'h020, 14'd6, t);
        for (int j = 0; j < 6; j++) begin
            push(0, KAddr, t + addr_off[j], 1024'(13'h020 + 13'(j)));
            push(0, KNext, t + next_off[j], exp_tile(13'h020 + 13'(j)));
        end
        push(0, KDone, t + 13, '0);
        @(posedge clk);
        #1;
        pause[0] = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        pause[0] = 1'b0;
        drain(40);

        // Zero-length run: done only, address untouched.
        do_start(0, 13'h0AB, 14'd0, t);
        push(0, KDone, t + 1, '0);
        push(0, KAddr, t + 1, 1024'(13'h025));
        push(0, KAddr, t + 2, 1024'(13'h025));
        push(0, KBusy, t + 1, 1024'(1));
        push(0, KBusy, t + 2, 1024'(0));
        drain(20);

        // Reset mid-run with five tiles still to issue.
        do_start(0, 13'h040, 14'd8, t);
        push(0, KAddr, t + 1, 1024'(13'h040));
        push(0, KAddr, t + 2, 1024'(13'h041));
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("midrun busy", 1024'(busy[0]), '0);
        chk("midrun done", 1024'(done[0]), '0);
        chk("midrun fft_next", 1024'(fft_next[0]), '0);
        chk("midrun address", 1024'(mem_read_address[0]), '0);
        chk("midrun fft_in", fft_in[0], '0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (8) @(posedge clk);
        do_start(0, 13'h050, 14'd2, t);
        expect_run(0, t, 13'h050, 2, 0);
        drain(40);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fft2d_tile_feeder.md
Name: fft2d_tile_feeder

Overview:
- Sequencer directly upstream of the 4x4 2-D FFT stage.
- Walks a run of consecutive 4x4 complex tiles in the image block memory (13-bit address, one 16-complex tile per word) and issues one read per tile.
- Presents each returned tile to the FFT input together with its one-cycle next pulse.
- Honours a pause from downstream and a programmable minimum gap between tiles.

Parameters:
- ADDR_WIDTH, 13, image memory address width.
- TILE_GAP, 0, minimum idle cycles inserted between successive read issues (0 = one tile per cycle).
- CNT_WIDTH, 14, width of the tile-count input (allows 0..8192).

Ports:
- clk  in  1  clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to begin a run; sampled only in IDLE.
- base_addr  in  ADDR_WIDTH  address of the first tile; sampled with start.
- num_tiles  in  CNT_WIDTH  number of tiles in the run; sampled with start.
- pause  in  1  downstream hold; blocks new read issues.
- busy  out  1  run in progress.
- done  out  1  one-cycle pulse at end of run.
- mem_read_address  out  ADDR_WIDTH  image memory read address (registered).
- mem_out  in  1024  tile from memory: 16 complex_t, element [r][c] at bits (r*4+c)*64 +: 64; valid the cycle after its address.
- fft_in  out  1024  tile to FFT, same packing (registered).
- fft_next  out  1  one-cycle strobe: fft_in holds a new tile this cycle.

Behaviour:
- Reset (async, immediate): state=IDLE; busy=0, done=0, fft_next=0, mem_read_address=0, fft_in=0, all counters 0. Reset mid-run abandons the run; no further fft_next.
- FSM states: IDLE, ISSUE, DRAIN, FINISH.
- IDLE: on start=1 with num_tiles>0, latch base and count, go to ISSUE, busy=1 next cycle. On start=1 with num_tiles=0, go to FINISH directly; no reads issued.
- ISSUE: in a cycle where pause=0 and the gap counter is 0, drive the next read issue:
  - mem_read_address = base+i (mod 2^ADDR_WIDTH, wraps 8191->0).
  - The issue-valid pipe is set, the remaining count is decremented, and the gap counter is loaded with TILE_GAP.
  - The gap counter decrements each cycle it is nonzero, including paused cycles.
  - When pause=1, no issue occurs and mem_read_address holds its value.
  - After the last issue, go to DRAIN.
- Pipeline: issue in cycle k (address on mem_read_address) -> mem_out valid in k+1 -> fft_in registered, fft_next=1 in k+2. Reads already issued always complete; pause never drops or stalls them.
- DRAIN: wait until the issue pipe is empty, i.e. the last fft_next has occurred, then go to FINISH.
- FINISH: done=1 for exactly one cycle, then busy=0 and return to IDLE. busy is high from the cycle after start through the done cycle inclusive.
- Latency: start in cycle T (pause=0) -> first address in T+1 -> first fft_next in T+3. With TILE_GAP=g, successive fft_next are g+1 cycles apart. Last fft_next in cycle L -> done in L+1.
- Run of N tiles with no pause produces exactly N fft_next pulses, in address order.
- start while busy: ignored; base_addr and num_tiles are not re-sampled.
- fft_in holds its last tile between strobes; it changes only on fft_next cycles.

Optional Feature:
- Macro FEEDER_REAL_INPUT_EN.
- Defined: the imaginary half (.i, low 32 bits of each 64-bit element) of every fft_in element is forced to 0; real parts pass unchanged. Used for real-valued image inputs.
- Undefined: mem_out is passed to fft_in unmodified.
- Timing is identical in both builds.

Test Plan:
- Reset mid-run: assert reset while ISSUE with 5 tiles left -> busy, done, fft_next fall immediately; no fft_next after release; next start works normally.
- Basic run: base_addr=0x010, num_tiles=4, TILE_GAP=0, start at T -> addresses 0x010..0x013 in T+1..T+4; fft_next in T+3..T+6; fft_in equals memory words in order; done at T+7.
- Wrap + gap: base_addr=0x1FFE, num_tiles=3, TILE_GAP=2 -> addresses 0x1FFE, 0x1FFF, 0x0000, three cycles apart; fft_next spacing 3 cycles.
- Pause: num_tiles=6, pause high for 4 cycles after the 2nd issue -> exactly 6 fft_next, address order preserved; in-flight tile still delivered; done delayed by 4 cycles.
- Zero/ignored start: num_tiles=0 -> done pulse with no mem_read_address change and no fft_next; start asserted while busy -> no effect on the current run.
- FEEDER_REAL_INPUT_EN build: memory word with element .i=0x3F800000 -> fft_in .i=0; .r unchanged; timing matches the default build.
